mem_access_seq: RTL and testbench
=================================

MEM_ACCESS_SEQ -- requirements
Module: mem_access_seq

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 16, the maximum memory wait cycles before abort (legal 1..255).
REQ-002 The block SHALL have port clock  in  1  the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port clear  in  1  reset, asynchronous and active-high.
REQ-004 The block SHALL have port start  in  1  request pulse from the control unit; sampled only in IDLE.
REQ-005 The block SHALL have port write  in  1  operation select sampled with start (0 = read, 1 = write).
REQ-006 The block SHALL have port mem_ready  in  1  memory completion acknowledge.
REQ-007 The block SHALL have port mar_enable  out  1  load MAR from bus.
REQ-008 The block SHALL have port mdr_enable  out  1  load MDR.
REQ-009 The block SHALL have port mdr_read  out  1  MDR source select (1 = Mdatain, 0 = BusMuxOut).
REQ-010 The block SHALL have port mdr_out  out  1  drive MDR onto the bus.
REQ-011 The block SHALL have port mem_read  out  1  memory read strobe.
REQ-012 The block SHALL have port mem_write  out  1  memory write strobe.
REQ-013 The block SHALL have port busy  out  1  high in every state except IDLE.
REQ-014 The block SHALL have port done  out  1  one-cycle completion pulse.
REQ-015 The block SHALL have port err  out  1  one-cycle timeout pulse, coincident with done.

Function
REQ-016 States SHALL be IDLE, MAR_LD, MEM_RD, MDR_LD, MDR_OUT, MEM_WR, DONE, ERROR; all outputs are decoded from the current state (Moore).
REQ-017 In IDLE, start=1 SHALL latch write and move to MAR_LD; start while busy SHALL be ignored, not queued.
REQ-018 MAR_LD SHALL assert mar_enable for one cycle, then go to MEM_RD (read) or MDR_LD (write).
REQ-019 MEM_RD SHALL hold mem_read=1 until mem_ready is sampled 1, then go to MDR_LD.
REQ-020 MDR_LD SHALL assert mdr_enable for one cycle with mdr_read=1 on a read (next MDR_OUT) and mdr_read=0 on a write (next MEM_WR).
REQ-021 MDR_OUT SHALL assert mdr_out for one cycle, then go to DONE.
REQ-022 MEM_WR SHALL hold mem_write=1 and mdr_out=1 until mem_ready is sampled 1, then go to DONE.
REQ-023 DONE SHALL assert done for one cycle and return to IDLE; start sampled in DONE SHALL be ignored.
REQ-024 Minimum latency from start edge to done high SHALL be 5 cycles for read, 4 for write; each cycle mem_ready is low in MEM_RD/MEM_WR adds exactly one cycle.
REQ-025 mem_ready outside MEM_RD/MEM_WR SHALL have no effect; mem_read and mem_write SHALL never be high together.

Reset
REQ-026 clear=1 SHALL immediately force IDLE, zero the wait counter and drive every output to 0, including mid-transaction with strobes active.
REQ-027 After clear deasserts, the first start SHALL be accepted on the next rising edge.

Configuration
REQ-028 With MEM_ACCESS_TIMEOUT_EN defined, an 8-bit wait counter SHALL clear on entry to MEM_RD/MEM_WR, increment each waiting cycle, and on reaching TIMEOUT_CYCLES without mem_ready go to ERROR.
REQ-029 ERROR SHALL drop all strobes, assert done=1 and err=1 for one cycle, then return to IDLE; mem_ready on the final counted cycle SHALL win over the timeout.
REQ-030 Without MEM_ACCESS_TIMEOUT_EN, the counter and ERROR state SHALL be absent, waits SHALL be unbounded, and err SHALL be tied 0.

Structure
REQ-031 The state encoding type and the read/write opcode constants SHALL live in shared package cpu_mem_pkg.
REQ-032 The wait counter SHALL be a sub-module mem_wait_timer (clear-on-entry, increment, terminal-count output), instantiated only when MEM_ACCESS_TIMEOUT_EN is defined.

Verification
REQ-033 Read, mem_ready tied 1: start pulse -> mar_enable cycle 1, mem_read cycle 2, mdr_enable+mdr_read cycle 3, mdr_out cycle 4, done cycle 5.
REQ-034 Write, mem_ready low 3 cycles in MEM_WR -> mem_write held 4 cycles, done at cycle 7, mdr_read=0 during MDR_LD.
REQ-035 Start held high continuously for 20 cycles -> exactly one transaction per IDLE visit, no start captured while busy.
REQ-036 clear asserted in MEM_RD with mem_read=1 -> all outputs 0 in the same cycle, IDLE, no done pulse.
REQ-037 MEM_ACCESS_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, mem_ready never high -> done=err=1 one cycle after 4 wait cycles, then IDLE.
REQ-038 Same build, mem_ready high on the 4th wait cycle -> normal completion, err stays 0.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared types for the memory access sequencer: state encoding and opcode constants.
// The ERROR state exists only when MEM_ACCESS_TIMEOUT_EN is defined.
package cpu_mem_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StMarLd,
    StMemRd,
    StMdrLd,
    StMdrOut,
    StMemWr,
`ifdef MEM_ACCESS_TIMEOUT_EN
    StDone,
    StError
`else
    StDone
`endif
  } state_e;

  localparam logic OpRead  = 1'b0;
  localparam logic OpWrite = 1'b1;

  localparam int unsigned CntWidth = 8;

  // States in which the sequencer waits on mem_ready.
  function automatic logic is_wait_state(input state_e s);
    return (s == StMemRd) || (s == StMemWr);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait counter: cleared on entry to a wait state, counts waiting cycles and flags
// the final allowed cycle. Only instantiated when MEM_ACCESS_TIMEOUT_EN is defined.
module mem_wait_timer
  import cpu_mem_pkg::*;
#(
  parameter int unsigned Limit = 16
) (
  input  logic clock,
  input  logic clear,
  input  logic restart,
  input  logic tick,
  output logic expired
);

  localparam logic [CntWidth-1:0] Last = CntWidth'(Limit - 1);

  logic [CntWidth-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (restart) begin
      count_d = '0;
    end else if (tick) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Terminal count marks the last wait cycle; mem_ready in that cycle still wins upstream.
  assign expired = (count_q == Last);

endmodule

// File: rtl/mem_access_seq.sv
// Moore sequencer driving MAR/MDR/memory strobes for one read or write per start pulse.
// Defining MEM_ACCESS_TIMEOUT_EN adds a bounded memory wait with an ERROR exit.
module mem_access_seq
  import cpu_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clock,
  input  logic clear,
  input  logic start,
  input  logic write,
  input  logic mem_ready,
  output logic mar_enable,
  output logic mdr_enable,
  output logic mdr_read,
  output logic mdr_out,
  output logic mem_read,
  output logic mem_write,
  output logic busy,
  output logic done,
  output logic err
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be within 1..255");
  end

  state_e state_q, state_d;
  logic   op_q;
  logic   timeout;

`ifdef MEM_ACCESS_TIMEOUT_EN
  logic timer_restart;
  logic timer_tick;

  assign timer_restart = is_wait_state(state_d) && !is_wait_state(state_q);
  assign timer_tick    = is_wait_state(state_q) && !mem_ready;

  mem_wait_timer #(
    .Limit(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clock   (clock),
    .clear   (clear),
    .restart (timer_restart),
    .tick    (timer_tick),
    .expired (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= StIdle;
      op_q    <= OpRead;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && start) begin
        op_q <= write;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (start) state_d = StMarLd;
      end
      StMarLd: begin
        state_d = (op_q == OpWrite) ? StMdrLd : StMemRd;
      end
      StMemRd: begin
        if (mem_ready) begin
          state_d = StMdrLd;
`ifdef MEM_ACCESS_TIMEOUT_EN
        end else if (timeout) begin
          state_d = StError;
`endif
        end
      end
      StMdrLd: begin
        state_d = (op_q == OpWrite) ? StMemWr : StMdrOut;
      end
      StMdrOut: begin
        state_d = StDone;
      end
      StMemWr: begin
        if (mem_ready) begin
          state_d = StDone;
`ifdef MEM_ACCESS_TIMEOUT_EN
        end else if (timeout) begin
          state_d = StError;
`endif
        end
      end
      StDone: begin
        state_d = StIdle;
      end
`ifdef MEM_ACCESS_TIMEOUT_EN
      StError: begin
        state_d = StIdle;
      end
`endif
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs depend only on the registered state, so clear zeroes them immediately.
  always_comb begin
    mar_enable = 1'b0;
    mdr_enable = 1'b0;
    mdr_read   = 1'b0;
    mdr_out    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    done       = 1'b0;
    busy       = (state_q != StIdle);
    case (state_q)
      StMarLd:  mar_enable = 1'b1;
      StMemRd:  mem_read   = 1'b1;
      StMdrLd: begin
        mdr_enable = 1'b1;
        mdr_read   = (op_q == OpRead);
      end
      StMdrOut: mdr_out    = 1'b1;
      StMemWr: begin
        mem_write = 1'b1;
        mdr_out   = 1'b1;
      end
      StDone:   done       = 1'b1;
`ifdef MEM_ACCESS_TIMEOUT_EN
      StError:  done       = 1'b1;
`endif
      default: ;
    endcase
  end

`ifdef MEM_ACCESS_TIMEOUT_EN
  assign err = (state_q == StError);
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_seq.sv
// Self-checking bench for mem_access_seq: per-cycle comparison against an expected output
// stream built from transaction descriptions, plus literal latency and reset checks.
module tb_mem_access_seq;

  localparam int Timeout = 4;

  // Vector order: {mar_enable, mdr_enable, mdr_read, mdr_out, mem_read, mem_write, busy, done, err}
  localparam logic [8:0] VecIdle  = 9'b0_0_0_0_0_0_0_0_0;
  localparam logic [8:0] VecMar   = 9'b1_0_0_0_0_0_1_0_0;
  localparam logic [8:0] VecMemRd = 9'b0_0_0_0_1_0_1_0_0;
  localparam logic [8:0] VecMdrR  = 9'b0_1_1_0_0_0_1_0_0;
  localparam logic [8:0] VecMdrW  = 9'b0_1_0_0_0_0_1_0_0;
  localparam logic [8:0] VecMdrOut = 9'b0_0_0_1_0_0_1_0_0;
  localparam logic [8:0] VecMemWr = 9'b0_0_0_1_0_1_1_0_0;
  localparam logic [8:0] VecDone  = 9'b0_0_0_0_0_0_1_1_0;
  localparam logic [8:0] VecErr   = 9'b0_0_0_0_0_0_1_1_1;

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int LatRd8 = 6;
  localparam int LatWr8 = 7;
`else
  localparam int LatRd8 = 13;
  localparam int LatWr8 = 12;
`endif

  logic clock = 1'b0;
  logic clear, start, write, mem_ready;
  logic mar_enable, mdr_enable, mdr_read, mdr_out, mem_read, mem_write, busy, done, err;

  int compared = 0;
  int mismatched = 0;
  logic [8:0] exp_q[$];

  always #5 clock = ~clock;

  mem_access_seq #(
    .TIMEOUT_CYCLES(Timeout)
  ) dut (
    .clock      (clock),
    .clear      (clear),
    .start      (start),
    .write      (write),
    .mem_ready  (mem_ready),
    .mar_enable (mar_enable),
    .mdr_enable (mdr_enable),
    .mdr_read   (mdr_read),
    .mdr_out    (mdr_out),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  function automatic logic [8:0] outs();
    return {mar_enable, mdr_enable, mdr_read, mdr_out, mem_read, mem_write, busy, done, err};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle: outputs must match the next queued expectation, or all-zero IDLE when none.
  always @(negedge clock) begin
    logic [8:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : VecIdle;
    check("cycle_outputs", int'(outs()), int'(e));
  end

  // Called #1 after a rising edge with the DUT idle; the first expected entry is this cycle.
  task automatic run_txn(input bit w, input int d, input bit rdy_all, input bit hold,
                         input int exp_lat, input string name);
    logic [8:0] vecs[$];
    bit rdys[$];
    int nwait;
    int lat;
    int model_lat;
    bit tmo;
    tmo = 1'b0;
    nwait = d;
`ifdef MEM_ACCESS_TIMEOUT_EN
    if (d >= Timeout) begin
      tmo = 1'b1;
      nwait = Timeout;
    end
`endif
    vecs.push_back(VecIdle); rdys.push_back(rdy_all);
    vecs.push_back(VecMar);  rdys.push_back(rdy_all);
    if (w) begin
      vecs.push_back(VecMdrW); rdys.push_back(rdy_all);
    end
    for (int i = 0; i < nwait; i++) begin
      vecs.push_back(w ? VecMemWr : VecMemRd); rdys.push_back(rdy_all);
    end
    if (tmo) begin
      vecs.push_back(VecErr); rdys.push_back(rdy_all);
    end else begin
      vecs.push_back(w ? VecMemWr : VecMemRd); rdys.push_back(1'b1);
      if (!w) begin
        vecs.push_back(VecMdrR);   rdys.push_back(rdy_all);
        vecs.push_back(VecMdrOut); rdys.push_back(rdy_all);
      end
      vecs.push_back(VecDone); rdys.push_back(rdy_all);
    end
    model_lat = -1;
    for (int i = 0; i < vecs.size(); i++) begin
      if (model_lat < 0 && vecs[i][1]) model_lat = i;
    end
    check({name, "_model_latency"}, model_lat, exp_lat);
    foreach (vecs[i]) exp_q.push_back(vecs[i]);
    start = 1'b1;
    write = w;
    mem_ready = rdys[0];
    lat = -1;
    for (int i = 1; i < vecs.size(); i++) begin
      @(posedge clock); #1;
      if (i == 1 && !hold) start = 1'b0;
      mem_ready = rdys[i];
      if (lat < 0 && done) lat = i;
    end
    @(posedge clock); #1;
    mem_ready = 1'b0;
    check({name, "_dut_latency"}, lat, exp_lat);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock); #1;
    end
  endtask

  initial begin
    clear = 1'b1;
    start = 1'b0;
    write = 1'b0;
    mem_ready = 1'b0;
    idle(2);
    check("reset_outputs", int'(outs()), int'(VecIdle));
    clear = 1'b0;
    idle(1);

    // Read with mem_ready tied high, including outside the wait state.
    run_txn(1'b0, 0, 1'b1, 1'b0, 5, "read_ready_tied");
    idle(1);
    // Write with mem_ready low for 3 wait cycles.
    run_txn(1'b1, 3, 1'b0, 1'b0, 7, "write_wait3");
    idle(2);
    run_txn(1'b0, 2, 1'b0, 1'b0, 7, "read_wait2");
    run_txn(1'b1, 0, 1'b0, 1'b0, 4, "write_nowait");
    idle(1);

    // start held high across back-to-back transactions: one per IDLE visit.
    run_txn(1'b0, 0, 1'b1, 1'b1, 5, "held_start_1");
    run_txn(1'b0, 0, 1'b1, 1'b1, 5, "held_start_2");
    run_txn(1'b0, 0, 1'b1, 1'b0, 5, "held_start_3");
    idle(2);

    // clear in MEM_RD with mem_read active.
    exp_q.push_back(VecIdle);
    exp_q.push_back(VecMar);
    exp_q.push_back(VecMemRd);
    start = 1'b1;
    write = 1'b0;
    mem_ready = 1'b0;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("pre_clear_mem_read", int'(mem_read), 1);
    #1 clear = 1'b1;
    #1 check("clear_immediate", int'(outs()), int'(VecIdle));
    @(posedge clock); #1;
    clear = 1'b0;
    run_txn(1'b0, 0, 1'b0, 1'b0, 5, "after_clear");
    idle(1);

    // Long waits: timeout exit when enabled, otherwise eventual completion.
    run_txn(1'b0, 8, 1'b0, 1'b0, LatRd8, "read_wait8");
    idle(1);
    run_txn(1'b1, 8, 1'b0, 1'b0, LatWr8, "write_wait8");
    idle(1);
    // Ready arrives on the last allowed wait cycle and must win.
    run_txn(1'b0, 3, 1'b0, 1'b0, 8, "read_ready_last");
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
